// File: rtl/apb_gpio_pkg.sv
// Register map shared by the APB GPIO controller and its per-pin input slices.
package apb_gpio_pkg;
    localparam int MAX_GPIO_W = 32;

    localparam logic [7:0] OFS_OUT     = 8'h00;
    localparam logic [7:0] OFS_DIR     = 8'h04;
    localparam logic [7:0] OFS_IN      = 8'h08;
    localparam logic [7:0] OFS_OUT_SET = 8'h0C;
    localparam logic [7:0] OFS_OUT_CLR = 8'h10;
    localparam logic [7:0] OFS_OUT_TGL = 8'h14;
    localparam logic [7:0] OFS_IRQ_EN  = 8'h18;
    localparam logic [7:0] OFS_RISE_EN = 8'h1C;
    localparam logic [7:0] OFS_FALL_EN = 8'h20;
    localparam logic [7:0] OFS_STAT    = 8'h24;
endpackage

// File: rtl/gpio_pin_in.sv
// One GPIO input slice: synchroniser, optional debounce filter (GPIO_DEBOUNCE_EN),
// previous-value flop and qualified rise/fall event outputs.
module gpio_pin_in
    import apb_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DB_CYCLES   = 16
`endif
) (
    input  logic pclk,
    input  logic presetn,
    input  logic pin,
    input  logic rise_en,
    input  logic fall_en,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;
    logic                   prev_p2;

    // Stage 0: metastability chain, oldest sample at the top bit
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) sync_p0 <= '0;
        else          sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
    end

    assign s = sync_p0[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [15:0] db_cnt;
    logic        level_p1;

    // Stage 1: accept a new level only after it has held for DB_CYCLES samples
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            db_cnt   <= '0;
            level_p1 <= 1'b0;
        end else if (s == level_p1) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            level_p1 <= s;
        end else begin
            db_cnt <= db_cnt + 16'd1;
        end
    end

    assign level = level_p1;
`else
    assign level = s;
`endif

    // Stage 2: previous value for edge detection
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) prev_p2 <= 1'b0;
        else          prev_p2 <= level;
    end

    assign rise = level & ~prev_p2 & rise_en;
    assign fall = ~level & prev_p2 & fall_en;
endmodule

// File: rtl/apb_gpio_irq.sv
// APB GPIO controller with atomic output updates and sticky W1C edge interrupts.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module apb_gpio_irq
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);
    if (GPIO_W < 1 || GPIO_W > MAX_GPIO_W || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_param
        $error("apb_gpio_irq: parameter out of range");
    end

    localparam int ARM_LAST = SYNC_STAGES + 1;

    logic [7:0]        ofs;
    logic              ofs_ok;
    logic              wr_en;
    logic [GPIO_W-1:0] wdata;
    logic [GPIO_W-1:0] out_q, dir_q, irq_en_q, rise_en_q, fall_en_q, stat_q;
    logic [GPIO_W-1:0] in_val, rise_ev, fall_ev, stat_clr, rd_val;
    logic [2:0]        arm_cnt;
    logic              armed;
    logic              unused_bits;

    assign ofs         = paddr[7:0];
    assign wdata       = pwdata[GPIO_W-1:0];
    assign unused_bits = ^{paddr[31:8], pwdata};

    // Misaligned offsets never match an entry, so they fall out as errors here.
    always_comb begin
        ofs_ok = 1'b0;
        case (ofs)
            OFS_OUT, OFS_DIR, OFS_IN, OFS_OUT_SET, OFS_OUT_CLR, OFS_OUT_TGL,
            OFS_IRQ_EN, OFS_RISE_EN, OFS_FALL_EN, OFS_STAT: ofs_ok = 1'b1;
            default:                                        ofs_ok = 1'b0;
        endcase
    end

    assign wr_en   = psel & penable & pwrite & ofs_ok;
    assign pslverr = psel & penable & ~ofs_ok;
    assign pready  = 1'b1;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            out_q     <= '0;
            dir_q     <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_en) begin
            case (ofs)
                OFS_OUT:     out_q     <= wdata;
                OFS_DIR:     dir_q     <= wdata;
                OFS_OUT_SET: out_q     <= out_q | wdata;
                OFS_OUT_CLR: out_q     <= out_q & ~wdata;
                OFS_OUT_TGL: out_q     <= out_q ^ wdata;
                OFS_IRQ_EN:  irq_en_q  <= wdata;
                OFS_RISE_EN: rise_en_q <= wdata;
                OFS_FALL_EN: fall_en_q <= wdata;
                default:     ;
            endcase
        end
    end

    // Holds off event capture until the synchronisers have flushed reset values
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)   arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end

    assign armed    = (arm_cnt == 3'(ARM_LAST));
    assign stat_clr = (wr_en && ofs == OFS_STAT) ? wdata : '0;

    // New events are ORed after the clear so a coincident event survives the W1C.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) stat_q <= '0;
        else          stat_q <= (stat_q & ~stat_clr) | (armed ? (rise_ev | fall_ev) : '0);
    end

    always_comb begin
        rd_val = '0;
        if (psel && !pwrite) begin
            case (ofs)
                OFS_OUT:     rd_val = out_q;
                OFS_DIR:     rd_val = dir_q;
                OFS_IN:      rd_val = in_val;
                OFS_IRQ_EN:  rd_val = irq_en_q;
                OFS_RISE_EN: rd_val = rise_en_q;
                OFS_FALL_EN: rd_val = fall_en_q;
                OFS_STAT:    rd_val = stat_q;
                default:     rd_val = '0;
            endcase
        end
        prdata               = '0;
        prdata[GPIO_W-1:0]   = rd_val;
    end

    for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
        gpio_pin_in #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            ,
            .DB_CYCLES  (DB_CYCLES)
`endif
        ) u_pin (
            .pclk    (pclk),
            .presetn (presetn),
            .pin     (gpio_in[i]),
            .rise_en (rise_en_q[i]),
            .fall_en (fall_en_q[i]),
            .level   (in_val[i]),
            .rise    (rise_ev[i]),
            .fall    (fall_ev[i])
        );
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(stat_q & irq_en_q);
endmodule
